// File: rtl/ddr_rd_return_pkg.sv
// ddr_rd_return_pkg: shared types and constants for the DDR4 read-return path.
// Holds the returned word layout, assembler states and default geometry.
package ddr_rd_return_pkg;

  localparam int RD_CL         = 11;
  localparam int RD_BL         = 8;
  localparam int RD_TAG_WIDTH  = 4;
  localparam int RD_DQ_WIDTH   = 8;
  localparam int RD_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [RD_TAG_WIDTH-1:0]      tag;
    logic [RD_DQ_WIDTH*RD_BL-1:0] data;
  } rd_return_type;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_asm_state_type;

  function automatic int rd_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_rd_return_if.sv
// ddr_rd_return_if: valid/ready return channel carrying {tag, data}.
// master drives ret_valid/ret_tag/ret_data, slave drives ret_ready.
interface ddr_rd_return_if
  import ddr_rd_return_pkg::*;
#(
  parameter int TAG_WIDTH  = RD_TAG_WIDTH,
  parameter int DATA_WIDTH = RD_DQ_WIDTH * RD_BL
);

  logic                  ret_valid;
  logic                  ret_ready;
  logic [TAG_WIDTH-1:0]  ret_tag;
  logic [DATA_WIDTH-1:0] ret_data;

  modport master (
    output ret_valid,
    output ret_tag,
    output ret_data,
    input  ret_ready
  );

  modport slave (
    input  ret_valid,
    input  ret_tag,
    input  ret_data,
    output ret_ready
  );

endinterface

// File: rtl/ddr_rd_return_fifo.sv
// rd_return_fifo: first-word-fall-through queue, DEPTH a power of 2.
// Ports: push/push_data, pop/pop_data (0 when empty), full, empty, count.
module rd_return_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock_t,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_t) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_rd_return.sv
// ddr_rd_return: READ CAS delay line, burst assembler and return queue.
// Ports: rd_issue/rd_tag/rd_credit, dq_lo/dq_hi/dbi_n, ret (if), proto_err; RD_DBI_EN enables DBI.
module ddr_rd_return
  import ddr_rd_return_pkg::*;
#(
  parameter int DQ_WIDTH   = RD_DQ_WIDTH,
  parameter int BL         = RD_BL,
  parameter int CL         = RD_CL,
  parameter int TAG_WIDTH  = RD_TAG_WIDTH,
  parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
  input  logic                    clock_t,
  input  logic                    reset_n,
  input  logic                    rd_issue,
  input  logic [TAG_WIDTH-1:0]    rd_tag,
  output logic                    rd_credit,
  input  logic [DQ_WIDTH-1:0]     dq_lo,
  input  logic [DQ_WIDTH-1:0]     dq_hi,
  input  logic [2*(DQ_WIDTH/8)-1:0] dbi_n,
  ddr_rd_return_if.master         ret,
  output logic                    proto_err
);

  localparam int NB  = DQ_WIDTH / 8;
  localparam int BW  = 2 * DQ_WIDTH;
  localparam int NBT = BL / 2;
  localparam int CW  = rd_cnt_width(NBT);
  localparam int DW  = DQ_WIDTH * BL;
  localparam int FW  = TAG_WIDTH + DW;
  localparam int QW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBT - 1);

  logic [CL-1:0]        dl_v;
  logic [TAG_WIDTH-1:0] dl_tag [CL];
  logic                 tail_v;
  logic [TAG_WIDTH-1:0] tail_tag;
  logic                 issue_ok;

  rd_asm_state_type     state_q;
  logic [CW-1:0]        bcnt_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [NBT-1:0][BW-1:0] data_q;
  logic [NBT-1:0][BW-1:0] data_mrg;
  logic [BW-1:0]        beat;
  logic                 burst_done;
  logic                 burst_next;

  logic [FW-1:0]        head;
  logic                 fifo_empty;
  logic                 fifo_full_unused;
  logic [QW-1:0]        fifo_cnt;
  logic                 pop;
  int                   inflight_d;

  assign tail_v   = dl_v[CL-1];
  assign tail_tag = dl_tag[CL-1];
  assign issue_ok = rd_issue && rd_credit;

`ifdef RD_DBI_EN
  function automatic logic [DQ_WIDTH-1:0] dbi_fix(
    input logic [DQ_WIDTH-1:0] b,
    input logic [NB-1:0]       f
  );
    logic [DQ_WIDTH-1:0] r;
    r = b;
    for (int k = 0; k < NB; k++)
      if (!f[k]) r[8*k +: 8] = ~b[8*k +: 8];
    return r;
  endfunction

  assign beat = {dbi_fix(dq_hi, dbi_n[2*NB-1:NB]),
                 dbi_fix(dq_lo, dbi_n[NB-1:0])};
`else
  logic dbi_unused;
  assign dbi_unused = ^dbi_n;
  assign beat = {dq_hi, dq_lo};
`endif

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      dl_v <= '0;
      for (int i = 0; i < CL; i++) dl_tag[i] <= '0;
    end else begin
      dl_v      <= {dl_v[CL-2:0], issue_ok};
      dl_tag[0] <= rd_tag;
      for (int i = 1; i < CL; i++) dl_tag[i] <= dl_tag[i-1];
    end
  end

  assign burst_done = (state_q == RD_BURST) && (bcnt_q == LAST);

  // Word pushed on the last beat already includes that beat.
  always_comb begin
    data_mrg         = data_q;
    data_mrg[bcnt_q] = beat;
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RD_IDLE;
      bcnt_q    <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (rd_issue && !rd_credit) proto_err <= 1'b1;
      unique case (state_q)
        RD_IDLE: begin
          if (tail_v) begin
            state_q   <= RD_BURST;
            bcnt_q    <= CW'(1);
            tag_q     <= tail_tag;
            data_q[0] <= beat;
          end
        end
        RD_BURST: begin
          data_q[bcnt_q] <= beat;
          if (!burst_done) begin
            bcnt_q <= bcnt_q + 1'b1;
            // a tail arriving mid-burst is dropped
            if (tail_v) proto_err <= 1'b1;
          end else if (tail_v) begin
            bcnt_q    <= CW'(1);
            tag_q     <= tail_tag;
            data_q[0] <= beat;
          end else begin
            state_q <= RD_IDLE;
            bcnt_q  <= '0;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign burst_next = (state_q == RD_IDLE) ? tail_v
                                           : (!burst_done || tail_v);

  // Credit counts every read not yet handed to the consumer.
  always_comb begin
    inflight_d = int'(issue_ok);
    for (int i = 0; i < CL-1; i++) inflight_d += int'(dl_v[i]);
    inflight_d += int'(burst_next);
    inflight_d += int'(fifo_cnt) + int'(burst_done) - int'(pop);
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) rd_credit <= 1'b1;
    else          rd_credit <= inflight_d < FIFO_DEPTH;
  end

  assign pop = ret.ret_valid && ret.ret_ready;

  rd_return_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clock_t   (clock_t),
    .reset_n   (reset_n),
    .push      (burst_done),
    .push_data ({tag_q, data_mrg}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign ret.ret_valid = !fifo_empty;
  assign ret.ret_tag   = head[FW-1:DW];
  assign ret.ret_data  = head[DW-1:0];

endmodule

// File: tb/tb_ddr_rd_return.sv
// tb_ddr_rd_return: scoreboard bench for the DDR4 read-return path.
// Drives issues and DQ bursts, predicts returns, compares at the consumer.
module tb_ddr_rd_return;
  import ddr_rd_return_pkg::*;

  localparam int CL = RD_CL;
`ifdef RD_DBI_EN
  localparam bit DBI_ON = 1'b1;
`else
  localparam bit DBI_ON = 1'b0;
`endif

  logic       clock_t;
  logic       reset_n;
  logic       rd_issue;
  logic [3:0] rd_tag;
  logic       rd_credit;
  logic [7:0] dq_lo;
  logic [7:0] dq_hi;
  logic [1:0] dbi_n;
  logic       proto_err;

  ddr_rd_return_if ret_if ();

  ddr_rd_return dut (
    .clock_t   (clock_t),
    .reset_n   (reset_n),
    .rd_issue  (rd_issue),
    .rd_tag    (rd_tag),
    .rd_credit (rd_credit),
    .dq_lo     (dq_lo),
    .dq_hi     (dq_hi),
    .dbi_n     (dbi_n),
    .ret       (ret_if),
    .proto_err (proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ret    = 0;
  rd_return_type sb[$];

  initial clock_t = 1'b0;
  always #5 clock_t = ~clock_t;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_t);
    #1;
  endtask

  function automatic logic [63:0] burst_word(input logic [7:0] base,
                                             input logic [1:0] dbi);
    logic [63:0] w;
    logic [7:0]  b;
    for (int i = 0; i < 8; i++) begin
      b = base + 8'(i);
      if (DBI_ON && !dbi[i%2]) b = ~b;
      w[8*i +: 8] = b;
    end
    return w;
  endfunction

  task automatic drive_burst(input logic [7:0] base, input logic [1:0] dbi);
    repeat (CL) tick();
    for (int j = 0; j < 4; j++) begin
      dq_lo = base + 8'(2*j);
      dq_hi = base + 8'(2*j+1);
      dbi_n = dbi;
      tick();
    end
    dq_lo = '0;
    dq_hi = '0;
    dbi_n = 2'b11;
  endtask

  // Issue in the current clock; returns one clock later.
  task automatic rd(input logic [3:0] tag, input logic [7:0] base,
                    input logic [1:0] dbi, input bit data_en,
                    input bit exp_ret);
    rd_return_type e;
    rd_issue = 1'b1;
    rd_tag   = tag;
    if (exp_ret) begin
      e.tag  = tag;
      e.data = burst_word(base, dbi);
      sb.push_back(e);
    end
    if (data_en) begin
      fork
        begin
          automatic logic [7:0] b = base;
          automatic logic [1:0] d = dbi;
          drive_burst(b, d);
        end
      join_none
    end
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || ret_if.ret_valid) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_valid", ret_if.ret_valid, 1'b0);
    check("rst_credit", rd_credit, 1'b1);
    check("rst_err", proto_err, 1'b0);
    sb.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  always @(negedge clock_t) begin
    if (reset_n && ret_if.ret_valid && ret_if.ret_ready) begin
      if (sb.size() == 0) begin
        check("ret_unexpected", ret_if.ret_valid, 1'b0);
      end else begin
        rd_return_type e;
        e = sb.pop_front();
        check("ret_tag", ret_if.ret_tag, e.tag);
        check("ret_data", ret_if.ret_data, e.data);
        n_ret++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base_ret;
    reset_n  = 1'b0;
    rd_issue = 1'b0;
    rd_tag   = '0;
    dq_lo    = '0;
    dq_hi    = '0;
    dbi_n    = 2'b11;
    ret_if.ret_ready = 1'b1;
    repeat (3) tick();
    @(negedge clock_t);
    check("reset_valid", ret_if.ret_valid, 1'b0);
    check("reset_credit", rd_credit, 1'b1);
    check("reset_err", proto_err, 1'b0);
    check("reset_tag", ret_if.ret_tag, 4'd0);
    check("reset_data", ret_if.ret_data, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single read: return CL+BL/2 clocks after issue
    rd(4'd3, 8'h01, 2'b11, 1'b1, 1'b1);
    repeat (CL+2) tick();
    @(negedge clock_t);
    check("single_early", ret_if.ret_valid, 1'b0);
    tick();
    @(negedge clock_t);
    check("single_valid", ret_if.ret_valid, 1'b1);
    check("single_tag", ret_if.ret_tag, 4'd3);
    check("single_data", ret_if.ret_data, 64'h0807060504030201);
    wait_drain("single_drain", 20);

    // back-to-back at tCCD = BL/2
    base_ret = n_ret;
    rd(4'd1, 8'h20, 2'b11, 1'b1, 1'b1);
    repeat (3) tick();
    rd(4'd2, 8'h40, 2'b11, 1'b1, 1'b1);
    repeat (10) tick();
    @(negedge clock_t);
    check("b2b_first", ret_if.ret_valid, 1'b1);
    check("b2b_first_tag", ret_if.ret_tag, 4'd1);
    repeat (4) tick();
    @(negedge clock_t);
    check("b2b_second", ret_if.ret_valid, 1'b1);
    check("b2b_second_tag", ret_if.ret_tag, 4'd2);
    wait_drain("b2b_drain", 20);
    check("b2b_count", 64'(n_ret - base_ret), 64'd2);
    check("b2b_err", proto_err, 1'b0);

    // backpressure: credit runs out at FIFO_DEPTH in flight
    ret_if.ret_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) begin
        @(negedge clock_t);
        check("bp_credit_before", rd_credit, 1'b1);
      end
      rd(4'(t), 8'(16*t + 8'h80), 2'b11, 1'b1, 1'b1);
      if (t < 3) repeat (3) tick();
    end
    @(negedge clock_t);
    check("bp_credit_low", rd_credit, 1'b0);
    repeat (2) tick();
    rd(4'd4, 8'hC0, 2'b11, 1'b0, 1'b0);
    @(negedge clock_t);
    check("bp_err", proto_err, 1'b1);
    repeat (CL+8) tick();
    @(negedge clock_t);
    check("bp_full_valid", ret_if.ret_valid, 1'b1);
    check("bp_head_tag", ret_if.ret_tag, 4'd0);
    check("bp_full_credit", rd_credit, 1'b0);
    ret_if.ret_ready = 1'b1;
    wait_drain("bp_drain", 30);
    check("bp_credit_back", rd_credit, 1'b1);

    // overlap: second tail lands mid-burst and is dropped
    do_reset();
    check("ov_err_clear", proto_err, 1'b0);
    base_ret = n_ret;
    rd(4'd5, 8'hA0, 2'b11, 1'b1, 1'b1);
    tick();
    rd(4'd6, 8'hB0, 2'b11, 1'b0, 1'b0);
    repeat (10) tick();
    @(negedge clock_t);
    check("ov_err_before", proto_err, 1'b0);
    tick();
    @(negedge clock_t);
    check("ov_err_set", proto_err, 1'b1);
    wait_drain("ov_drain", 20);
    repeat (8) tick();
    check("ov_count", 64'(n_ret - base_ret), 64'd1);

    // reset mid-burst discards the partial word
    do_reset();
    base_ret = n_ret;
    rd(4'd7, 8'h70, 2'b11, 1'b1, 1'b1);
    repeat (CL) tick();
    do_reset();
    repeat (CL+8) tick();
    @(negedge clock_t);
    check("mid_rst_valid", ret_if.ret_valid, 1'b0);
    check("mid_rst_count", 64'(n_ret - base_ret), 64'd0);

    // DBI lane inversion on the even beat
    rd(4'd9, 8'hF0, 2'b10, 1'b1, 1'b1);
    repeat (CL+3) tick();
    @(negedge clock_t);
    check("dbi_valid", ret_if.ret_valid, 1'b1);
    check("dbi_beat0", ret_if.ret_data[7:0], DBI_ON ? 8'h0F : 8'hF0);
    wait_drain("dbi_drain", 20);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_return.md
Name: ddr_rd_return

Overview:
- Read-data return path of the DDR4 controller model; the receive counterpart of the command/write-data pipeline.
- Timestamps each issued READ CAS and waits CL clocks for the data.
- Captures the deserialized DQ burst from the memory model and assembles BL beats into one word.
- Queues finished words to the requester with a valid/ready handshake.

Parameters:
- DQ_WIDTH, 8, bits per DQ beat.
- BL, 8, beats per burst (even; two beats per clock_t).
- CL, 11, clocks from rd_issue to first data clock (CL >= 2).
- TAG_WIDTH, 4, request tag width.
- FIFO_DEPTH, 4, output queue entries (power of 2).

Ports:
- clock_t  in  1  main clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_issue  in  1  pulse: READ CAS driven on cmd pins this clock.
- rd_tag  in  TAG_WIDTH  tag for rd_issue.
- rd_credit  out  1  high when a new rd_issue may be accepted.
- dq_lo  in  DQ_WIDTH  even beat this clock (rising-edge data).
- dq_hi  in  DQ_WIDTH  odd beat this clock (falling-edge data).
- dbi_n  in  2*(DQ_WIDTH/8)  per-byte DBI flags {hi,lo}; used only with RD_DBI_EN.
- ret_valid  out  1  assembled burst available.
- ret_ready  in  1  consumer accepts.
- ret_tag  out  TAG_WIDTH  tag of head entry.
- ret_data  out  DQ_WIDTH*BL  burst; beat0 at LSBs.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset: async assert clears the delay line, burst state, FIFO and counters. All outputs reset to 0 except rd_credit=1. Reset mid-burst discards partial data.
- Delay line: CL-stage shift register of {valid,tag}. rd_issue accepted when rd_credit=1; the entry reaches the tail at clock N+CL for issue at clock N. That clock is data clock 0.
- Assembler FSM, beat counter bcnt 0..BL/2-1:
  - IDLE: on tail valid, capture {dq_hi,dq_lo} into slot 0, latch tag, bcnt=1, go BURST.
  - BURST: capture into slot bcnt each clock. At bcnt=BL/2-1, push {tag,data} into FIFO.
    - Tail valid in the same clock: start the next burst seamlessly (bcnt=0 capture, stay BURST; tCCD=BL/2 back-to-back).
    - Otherwise go IDLE.
  - Tail valid while bcnt != last (overlap): set proto_err, drop the new entry, keep the current burst.
- Credit: inflight = delay-line valids + (FSM in BURST) + FIFO count. rd_credit = inflight < FIFO_DEPTH, registered from the next-state count. The FIFO therefore can never overflow on push.
- rd_issue while rd_credit=0: ignored, proto_err set.
- FIFO:
  - First-word-fall-through; ret_valid = !empty.
  - Pop on ret_valid&&ret_ready; push and pop in the same clock are both honoured.
  - Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
  - Latency: last data clock -> ret_valid next clock. Minimum rd_issue -> ret_valid = CL+BL/2.
- proto_err clears only on reset.

Optional Feature:
- RD_DBI_EN defined: each byte lane of each beat is inverted before storage when its dbi_n bit is 0; lane k of dq_lo uses dbi_n[k], lane k of dq_hi uses dbi_n[DQ_WIDTH/8+k].
- Undefined: dbi_n is ignored and data is stored raw.

Decomposition:
- Shared ddr_package.pkg gains:
  - rd_return_type struct {tag, data}.
  - Constants RD_CL, RD_BL, RD_TAG_WIDTH.
  - enum rd_asm_state_type {RD_IDLE, RD_BURST}.
- One sub-module, rd_return_fifo: parameterised depth/width FWFT queue with full, empty and count outputs.

Test Plan:
- Single read: rd_issue tag=3 at clk 10, dq_lo/dq_hi = 0x01..0x08 at clks 21-24 -> ret_valid at clk 25, ret_tag=3, ret_data=0x0807060504030201.
- Back-to-back reads: issues at clks 10 and 14 (tags 1, 2) with ret_ready=1 -> two returns at clks 25 and 29, no proto_err.
- Backpressure: ret_ready=0, 4 reads issued every 4 clks -> rd_credit falls after the 4th issue; a 5th rd_issue sets proto_err; raising ret_ready drains tags in order 0..3.
- Overlap: issues at clks 10 and 12 -> first burst intact, second dropped, proto_err=1 at clk 24.
- Reset mid-burst: reset_n low at clk 22 -> ret_valid=0 and rd_credit=1 immediately; no return after release.
- RD_DBI_EN: dq_lo=0xF0 with dbi_n[0]=0 -> stored beat 0x0F; same stimulus without the macro -> 0xF0.
